// File: rtl/safe_alu_pkg.sv
// Shared opcode encodings for the pipelined safe ALU.
// Saturation option is selected with SAFE_ALU_SATURATE_EN.
package safe_alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_ADC = 3'b101;
    localparam logic [OP_W-1:0] OP_SBC = 3'b110;
    localparam logic [OP_W-1:0] OP_SHL = 3'b111;

endpackage

// File: rtl/safe_alu_core.sv
// Combinational ALU datapath; clamps signed overflow when
// SAFE_ALU_SATURATE_EN is defined.
module safe_alu_core
    import safe_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             cy_in,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             cy_upd
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] ext;
    logic [WIDTH:0] cy_ext;

    assign cy_ext = {{WIDTH{1'b0}}, cy_in};

    always_comb begin
        ext      = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        cy_upd   = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                ext = {1'b0, a} + {1'b0, b}
                    + ((op == OP_ADC) ? cy_ext : '0);
                result   = ext[M:0];
                carry    = ext[WIDTH];
                overflow = (a[M] == b[M]) && (result[M] != a[M]);
                cy_upd   = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the extended difference is the borrow
                ext = {1'b0, a} - {1'b0, b}
                    - ((op == OP_SBC) ? cy_ext : '0);
                result   = ext[M:0];
                carry    = ext[WIDTH];
                overflow = (a[M] != b[M]) && (result[M] != a[M]);
                cy_upd   = 1'b1;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result   = {a[M-1:0], 1'b0};
                carry    = a[M];
                overflow = a[M] ^ a[M-1];
                cy_upd   = 1'b1;
            end
            default: result = '0;
        endcase
`ifdef SAFE_ALU_SATURATE_EN
        if (overflow && (op != OP_SHL)) begin
            result = a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/safe_alu_pipe.sv
// Two-stage valid/ready safe ALU with carry chaining and sticky overflow.
// Optional result saturation: define SAFE_ALU_SATURATE_EN.
module safe_alu_pipe
    import safe_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    logic             adv;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             cy_q;

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;
    logic             core_cy_upd;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~rst;

    safe_alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .op       (s1_op),
        .cy_in    (cy_q),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_ovf),
        .cy_upd   (core_cy_upd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            negative   <= 1'b0;
            cy_q       <= 1'b0;
            sticky_ovf <= 1'b0;
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                s1_a      <= a;
                s1_b      <= b;
                s1_op     <= opcode;
                out_valid <= s1_valid;
                if (s1_valid) begin
                    result   <= core_result;
                    zero     <= (core_result == '0);
                    carry    <= core_carry;
                    overflow <= core_ovf;
                    negative <= core_result[WIDTH-1];
                    if (core_cy_upd) cy_q <= core_carry;
                end
            end
            // A set event in the same cycle as a clear takes priority
            if (out_valid && out_ready && overflow) begin
                sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
            end
        end
    end

endmodule
